tcam_request_scheduler: RTL and testbench

Front-end stage directly upstream of the TCAM controller top.
- Accepts search and setting requests over a valid/ready interface and buffers them in a small FIFO.
- Issues one request at a time to the controller as a single-cycle SEARCH or SETTING pulse, holding the key and setting fields stable until the matching complete arrives.
- Returns a tagged response carrying rule ID, mismatch and timeout status.

---
 rtl/tcam_pkg.sv | 35 +++
 rtl/tcam_req_fifo.sv | 54 +++++
 rtl/tcam_request_scheduler.sv | 148 ++++++++++++++
 tb/tb_tcam_request_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_pkg.sv
// Shared widths, op encoding, FSM states and request layout for the TCAM request front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tcam_pkg;

    localparam int KWID    = 10;
    localparam int IDWID   = 2;
    localparam int PRIOWID = IDWID;
    localparam int MASKWID = 5;
    localparam int TAGWID  = 4;
    localparam int SEGWID  = 2 + IDWID + MASKWID + KWID + PRIOWID;

    localparam logic OP_SEARCH  = 1'b0;
    localparam logic OP_SETTING = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // "priority" is a keyword, so the field is named prio
    typedef struct packed {
        logic               op;
        logic [KWID-1:0]    key;
        logic [IDWID-1:0]   id;
        logic [MASKWID-1:0] maskid;
        logic [PRIOWID-1:0] prio;
        logic [TAGWID-1:0]  tag;
    } req_t;

    localparam int REQ_W = $bits(req_t);

endpackage

// File: rtl/tcam_req_fifo.sv
// Generic synchronous FIFO with occupancy count; head word is presented combinationally.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: pushes are refused while full (even with a same-cycle pop); pops of an empty FIFO are ignored.
module tcam_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AWID  = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic [AWID:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AWID-1:0]  wr_ptr;
    logic [AWID-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AWID+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push_vld & ~full;
    assign do_pop  = pop_vld & ~empty;
    assign pop_dat = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; a flush is just a pointer/count reset
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/tcam_request_scheduler.sv
// Buffers search/setting requests and issues them one at a time to the TCAM controller, returning tagged responses.
// Latency: accept at edge N -> pop N+1 -> TCAM pulse after N+2; response registered on the edge that samples the complete.
// Backpressure: REQ_READY low while the FIFO is full; response held in RESP until RSP_READY, stalling further issue.
module tcam_request_scheduler
    import tcam_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int FIFO_AWID      = 2,
    parameter int TO_WID         = 10,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic                 REQ_OP,
    input  logic [KWID-1:0]      REQ_KEY,
    input  logic [IDWID-1:0]     REQ_ID,
    input  logic [MASKWID-1:0]   REQ_MASKID,
    input  logic [PRIOWID-1:0]   REQ_PRIORITY,
    input  logic [TAGWID-1:0]    REQ_TAG,
    output logic                 TCAM_SEARCH,
    output logic                 TCAM_SETTING,
    output logic [KWID-1:0]      TCAM_KEY,
    output logic [IDWID-1:0]     TCAM_SETTING_ID,
    output logic [MASKWID-1:0]   TCAM_SETTING_MASKID,
    output logic [PRIOWID-1:0]   TCAM_SETTING_PRIORITY,
    input  logic [IDWID-1:0]     TCAM_RULEID,
    input  logic                 TCAM_MISMATCH,
    input  logic                 TCAM_SEARCH_COMPLETE,
    input  logic                 TCAM_SETTING_COMPLETE,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic                 RSP_OP,
    output logic [TAGWID-1:0]    RSP_TAG,
    output logic [IDWID-1:0]     RSP_RULEID,
    output logic                 RSP_MISMATCH,
    output logic                 RSP_TIMEOUT,
    output logic [FIFO_AWID:0]   FIFO_COUNT,
    output logic                 BUSY
);

    state_t             state;
    state_t             state_nxt;
    req_t               req_in;
    req_t               fifo_head;
    req_t               cmd;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               done_hit;
    logic               to_hit;
    logic [TO_WID-1:0]  to_cnt;

    assign req_in = '{op: REQ_OP, key: REQ_KEY, id: REQ_ID, maskid: REQ_MASKID,
                      prio: REQ_PRIORITY, tag: REQ_TAG};

    tcam_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH),
        .AWID  (FIFO_AWID)
    ) u_fifo (
        .CLK      (CLK),
        .RESET    (RESET),
        .push_vld (REQ_VALID),
        .push_dat (req_in),
        .pop_vld  (fifo_pop),
        .pop_dat  (fifo_head),
        .count    (FIFO_COUNT),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign REQ_READY             = ~fifo_full;
    assign RSP_VALID             = (state == ST_RESP);
    assign BUSY                  = (state != ST_IDLE) | ~fifo_empty;
    assign TCAM_KEY              = cmd.key;
    assign TCAM_SETTING_ID       = cmd.id;
    assign TCAM_SETTING_MASKID   = cmd.maskid;
    assign TCAM_SETTING_PRIORITY = cmd.prio;

    // Next-state decode; only the complete matching the held op counts, and it beats a same-cycle timeout
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        done_hit  = 1'b0;
        to_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                done_hit = (cmd.op == OP_SEARCH) ? TCAM_SEARCH_COMPLETE : TCAM_SETTING_COMPLETE;
                to_hit   = !done_hit && (to_cnt == TO_WID'(TIMEOUT_CYCLES - 1));
                if (done_hit || to_hit) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (RSP_READY) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Command hold, issue pulses, WAIT timer and response capture
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd          <= '0;
            to_cnt       <= '0;
            TCAM_SEARCH  <= 1'b0;
            TCAM_SETTING <= 1'b0;
            RSP_OP       <= 1'b0;
            RSP_TAG      <= '0;
            RSP_RULEID   <= '0;
            RSP_MISMATCH <= 1'b0;
            RSP_TIMEOUT  <= 1'b0;
        end else begin
            TCAM_SEARCH  <= (state == ST_ISSUE) && (cmd.op == OP_SEARCH);
            TCAM_SETTING <= (state == ST_ISSUE) && (cmd.op == OP_SETTING);
            if (fifo_pop) cmd <= fifo_head;
            if (state == ST_ISSUE)     to_cnt <= '0;
            else if (state == ST_WAIT) to_cnt <= to_cnt + 1'b1;
            if (done_hit) begin
                RSP_OP       <= cmd.op;
                RSP_TAG      <= cmd.tag;
                RSP_RULEID   <= (cmd.op == OP_SEARCH) ? TCAM_RULEID : cmd.id;
                RSP_MISMATCH <= (cmd.op == OP_SEARCH) ? TCAM_MISMATCH : 1'b0;
                RSP_TIMEOUT  <= 1'b0;
            end else if (to_hit) begin
                RSP_OP       <= cmd.op;
                RSP_TAG      <= cmd.tag;
                RSP_RULEID   <= '0;
                RSP_MISMATCH <= 1'b1;
                RSP_TIMEOUT  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tcam_request_scheduler.sv
// Directed bench for tcam_request_scheduler: hand-computed timing and response values.
// Latency: stimulus driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: RSP_READY toggled per scenario; every wait on the DUT is bounded.
module tb_tcam_request_scheduler;

    localparam int LIMIT = 64;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_OP;
    logic [9:0]  REQ_KEY;
    logic [1:0]  REQ_ID;
    logic [4:0]  REQ_MASKID;
    logic [1:0]  REQ_PRIORITY;
    logic [3:0]  REQ_TAG;
    logic        TCAM_SEARCH;
    logic        TCAM_SETTING;
    logic [9:0]  TCAM_KEY;
    logic [1:0]  TCAM_SETTING_ID;
    logic [4:0]  TCAM_SETTING_MASKID;
    logic [1:0]  TCAM_SETTING_PRIORITY;
    logic [1:0]  TCAM_RULEID;
    logic        TCAM_MISMATCH;
    logic        TCAM_SEARCH_COMPLETE;
    logic        TCAM_SETTING_COMPLETE;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic        RSP_OP;
    logic [3:0]  RSP_TAG;
    logic [1:0]  RSP_RULEID;
    logic        RSP_MISMATCH;
    logic        RSP_TIMEOUT;
    logic [2:0]  FIFO_COUNT;
    logic        BUSY;

    int n_checks = 0;
    int n_errors = 0;

    tcam_request_scheduler dut (
        .CLK                   (CLK),
        .RESET                 (RESET),
        .REQ_VALID             (REQ_VALID),
        .REQ_READY             (REQ_READY),
        .REQ_OP                (REQ_OP),
        .REQ_KEY               (REQ_KEY),
        .REQ_ID                (REQ_ID),
        .REQ_MASKID            (REQ_MASKID),
        .REQ_PRIORITY          (REQ_PRIORITY),
        .REQ_TAG               (REQ_TAG),
        .TCAM_SEARCH           (TCAM_SEARCH),
        .TCAM_SETTING          (TCAM_SETTING),
        .TCAM_KEY              (TCAM_KEY),
        .TCAM_SETTING_ID       (TCAM_SETTING_ID),
        .TCAM_SETTING_MASKID   (TCAM_SETTING_MASKID),
        .TCAM_SETTING_PRIORITY (TCAM_SETTING_PRIORITY),
        .TCAM_RULEID           (TCAM_RULEID),
        .TCAM_MISMATCH         (TCAM_MISMATCH),
        .TCAM_SEARCH_COMPLETE  (TCAM_SEARCH_COMPLETE),
        .TCAM_SETTING_COMPLETE (TCAM_SETTING_COMPLETE),
        .RSP_VALID             (RSP_VALID),
        .RSP_READY             (RSP_READY),
        .RSP_OP                (RSP_OP),
        .RSP_TAG               (RSP_TAG),
        .RSP_RULEID            (RSP_RULEID),
        .RSP_MISMATCH          (RSP_MISMATCH),
        .RSP_TIMEOUT           (RSP_TIMEOUT),
        .FIFO_COUNT            (FIFO_COUNT),
        .BUSY                  (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request and hold it until the edge that accepts it
    task automatic send(input logic op, input logic [9:0] key, input logic [1:0] id,
                        input logic [4:0] mask, input logic [1:0] prio, input logic [3:0] tag);
        logic accepted;
        accepted     = 1'b0;
        REQ_OP       = op;
        REQ_KEY      = key;
        REQ_ID       = id;
        REQ_MASKID   = mask;
        REQ_PRIORITY = prio;
        REQ_TAG      = tag;
        REQ_VALID    = 1'b1;
        for (int n = 0; n < LIMIT; n++) begin
            if (REQ_READY) begin
                accepted = 1'b1;
                tick();
                break;
            end
            tick();
        end
        REQ_VALID = 1'b0;
        check("req_accepted", accepted, 1);
    endtask

    // Count cycles until an issue pulse is seen
    task automatic wait_pulse(output int cycles);
        cycles = 0;
        while (!(TCAM_SEARCH || TCAM_SETTING) && cycles < LIMIT) begin
            tick();
            cycles++;
        end
        check("pulse_seen", (TCAM_SEARCH || TCAM_SETTING), 1);
    endtask

    // One-cycle controller complete; on return the DUT has sampled it
    task automatic complete(input logic search, input logic [1:0] rid, input logic mism);
        TCAM_RULEID   = rid;
        TCAM_MISMATCH = mism;
        if (search) TCAM_SEARCH_COMPLETE  = 1'b1;
        else        TCAM_SETTING_COMPLETE = 1'b1;
        tick();
        TCAM_SEARCH_COMPLETE  = 1'b0;
        TCAM_SETTING_COMPLETE = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int   gap;
        logic key_bad;
        logic early;

        RESET = 1'b1; REQ_VALID = 1'b0; REQ_OP = 1'b0; REQ_KEY = '0; REQ_ID = '0;
        REQ_MASKID = '0; REQ_PRIORITY = '0; REQ_TAG = '0; TCAM_RULEID = '0;
        TCAM_MISMATCH = 1'b0; TCAM_SEARCH_COMPLETE = 1'b0; TCAM_SETTING_COMPLETE = 1'b0;
        RSP_READY = 1'b0;
        repeat (3) tick();
        RESET = 1'b0;

        // Reset state
        check("rst_req_ready", REQ_READY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_count", FIFO_COUNT, 0);
        check("rst_key", TCAM_KEY, 0);

        // 1: single search, pulse two cycles after accept
        send(1'b0, 10'h2A5, 2'd0, 5'd0, 2'd0, 4'd3);
        check("t1_count_after_push", FIFO_COUNT, 1);
        check("t1_busy", BUSY, 1);
        tick();
        check("t1_no_pulse_yet", TCAM_SEARCH, 0);
        check("t1_popped", FIFO_COUNT, 0);
        tick();
        check("t1_search_pulse", TCAM_SEARCH, 1);
        check("t1_no_setting", TCAM_SETTING, 0);
        check("t1_key", TCAM_KEY, 10'h2A5);
        tick();
        check("t1_pulse_one_cycle", TCAM_SEARCH, 0);
        key_bad = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (TCAM_KEY !== 10'h2A5 || RSP_VALID !== 1'b0) key_bad = 1'b1;
        end
        check("t1_key_stable", key_bad, 0);
        complete(1'b1, 2'd2, 1'b0);
        check("t1_rsp_valid", RSP_VALID, 1);
        check("t1_rsp_tag", RSP_TAG, 3);
        check("t1_rsp_ruleid", RSP_RULEID, 2);
        check("t1_rsp_mismatch", RSP_MISMATCH, 0);
        check("t1_rsp_timeout", RSP_TIMEOUT, 0);
        check("t1_rsp_op", RSP_OP, 0);
        tick();
        check("t1_rsp_held", RSP_VALID, 1);
        RSP_READY = 1'b1;
        tick();
        check("t1_rsp_dropped", RSP_VALID, 0);
        check("t1_idle", BUSY, 0);

        // 2: setting request; wrong-type complete ignored, ruleid comes from the held ID
        RSP_READY = 1'b0;
        send(1'b1, 10'h155, 2'd1, 5'h1F, 2'd3, 4'd7);
        wait_pulse(gap);
        check("t2_setting_pulse", TCAM_SETTING, 1);
        check("t2_no_search", TCAM_SEARCH, 0);
        check("t2_id", TCAM_SETTING_ID, 1);
        check("t2_maskid", TCAM_SETTING_MASKID, 5'h1F);
        check("t2_prio", TCAM_SETTING_PRIORITY, 3);
        check("t2_key", TCAM_KEY, 10'h155);
        repeat (4) tick();
        complete(1'b1, 2'd2, 1'b1);
        check("t2_wrong_complete", RSP_VALID, 0);
        complete(1'b0, 2'd3, 1'b1);
        check("t2_rsp_valid", RSP_VALID, 1);
        check("t2_rsp_op", RSP_OP, 1);
        check("t2_rsp_tag", RSP_TAG, 7);
        check("t2_rsp_ruleid", RSP_RULEID, 1);
        check("t2_rsp_mismatch", RSP_MISMATCH, 0);
        RSP_READY = 1'b1;
        tick();
        check("t2_rsp_dropped", RSP_VALID, 0);

        // 3: fill the FIFO, refuse while full, then drain in order
        RSP_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(1'b0, 10'h100 + 10'(i), 2'd0, 5'd0, 2'd0, 4'(i));
            if (i == 1) check("t3_push_pop_same_cycle", FIFO_COUNT, 1);
        end
        check("t3_count_full", FIFO_COUNT, 4);
        check("t3_ready_low", REQ_READY, 0);
        REQ_OP = 1'b0; REQ_KEY = 10'h3FF; REQ_TAG = 4'hF; REQ_VALID = 1'b1;
        repeat (3) tick();
        REQ_VALID = 1'b0;
        check("t3_full_refused", FIFO_COUNT, 4);
        check("t3_head_key", TCAM_KEY, 10'h100);
        RSP_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                wait_pulse(gap);
                check("t3_issue_gap", gap, 3);
                check("t3_key_order", TCAM_KEY, 10'h100 + 10'(i));
                repeat (2) tick();
            end
            complete(1'b1, 2'(i), i[0]);
            check("t3_rsp_valid", RSP_VALID, 1);
            check("t3_rsp_tag", RSP_TAG, i);
            check("t3_rsp_ruleid", RSP_RULEID, i % 4);
            check("t3_rsp_mismatch", RSP_MISMATCH, i % 2);
        end
        tick();
        check("t3_drained", BUSY, 0);

        // 4: timeout after exactly 1023 WAIT cycles; late complete ignored
        RSP_READY = 1'b0;
        send(1'b0, 10'h3C3, 2'd0, 5'd0, 2'd0, 4'd9);
        wait_pulse(gap);
        early = 1'b0;
        for (int i = 0; i < 1022; i++) begin
            tick();
            if (RSP_VALID !== 1'b0) early = 1'b1;
        end
        check("t4_no_early_rsp", early, 0);
        tick();
        check("t4_rsp_valid", RSP_VALID, 1);
        check("t4_timeout", RSP_TIMEOUT, 1);
        check("t4_mismatch", RSP_MISMATCH, 1);
        check("t4_ruleid", RSP_RULEID, 0);
        check("t4_tag", RSP_TAG, 9);
        RSP_READY = 1'b1;
        tick();
        check("t4_rsp_dropped", RSP_VALID, 0);
        complete(1'b1, 2'd3, 1'b0);
        check("t4_late_ignored", RSP_VALID, 0);
        check("t4_late_idle", BUSY, 0);
        send(1'b0, 10'h0F0, 2'd0, 5'd0, 2'd0, 4'd4);
        wait_pulse(gap);
        repeat (3) tick();
        complete(1'b1, 2'd3, 1'b1);
        check("t4_next_valid", RSP_VALID, 1);
        check("t4_next_tag", RSP_TAG, 4);
        check("t4_next_ruleid", RSP_RULEID, 3);
        check("t4_next_mismatch", RSP_MISMATCH, 1);
        check("t4_next_timeout", RSP_TIMEOUT, 0);
        tick();

        // 5: wrong complete ignored; matching complete on the timeout cycle wins
        RSP_READY = 1'b0;
        send(1'b0, 10'h2AA, 2'd0, 5'd0, 2'd0, 4'd5);
        wait_pulse(gap);
        repeat (2) tick();
        complete(1'b0, 2'd2, 1'b1);
        check("t5_wrong_complete", RSP_VALID, 0);
        repeat (1019) tick();
        check("t5_before_last", RSP_VALID, 0);
        complete(1'b1, 2'd1, 1'b0);
        check("t5_rsp_valid", RSP_VALID, 1);
        check("t5_complete_wins", RSP_TIMEOUT, 0);
        check("t5_mismatch", RSP_MISMATCH, 0);
        check("t5_ruleid", RSP_RULEID, 1);
        RSP_READY = 1'b1;
        tick();

        // 6: reset mid-WAIT with two requests queued
        RSP_READY = 1'b0;
        send(1'b0, 10'h011, 2'd0, 5'd0, 2'd0, 4'd1);
        send(1'b0, 10'h022, 2'd0, 5'd0, 2'd0, 4'd2);
        send(1'b0, 10'h033, 2'd0, 5'd0, 2'd0, 4'd3);
        check("t6_queued", FIFO_COUNT, 2);
        repeat (3) tick();
        check("t6_busy", BUSY, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("t6_count", FIFO_COUNT, 0);
        check("t6_busy_clr", BUSY, 0);
        check("t6_rsp_valid", RSP_VALID, 0);
        check("t6_key", TCAM_KEY, 0);
        check("t6_pulse", TCAM_SEARCH, 0);
        check("t6_ready", REQ_READY, 1);
        complete(1'b1, 2'd2, 1'b0);
        check("t6_late_ignored", RSP_VALID, 0);
        check("t6_still_idle", BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
